// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  // Control register offsets, relative to H = NUM_DIGITS/2 (VALUE bytes occupy 0..H-1)
  localparam int unsigned OFF_DP     = 0;
  localparam int unsigned OFF_EN     = 1;
  localparam int unsigned OFF_BRIGHT = 2;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Active-low g..a patterns, entry 15 (F) first down to entry 0
  localparam logic [15:0][SEG_W-1:0] HEX_SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       digit_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = HEX_SEG_LUT[digit_i];

endmodule

// File: rtl/seg7_mux_driver.sv
// Bus-mapped multiplexed common-anode 7-segment driver with blanking and digit mask.
// Optional PWM brightness register enabled by defining SEG7_MUX_BRIGHTNESS_EN.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR    = 8'hD0,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [7:0]            BUS_ADDR,
  input  logic [7:0]            BUS_DATA,
  input  logic                  BUS_WE,
  output logic [7:0]            HEX_OUT,
  output logic [NUM_DIGITS-1:0] SEG_SELECT
);

  localparam int unsigned H       = NUM_DIGITS / 2;
  localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
`ifdef SEG7_MUX_BRIGHTNESS_EN
  localparam int unsigned NUM_REGS = H + 3;
`else
  localparam int unsigned NUM_REGS = H + 2;
`endif

  scan_state_e           state_q, state_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      value_q, value_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [7:0]            hex_q, hex_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic [7:0]            off_c;
  logic                  wr_c;
  logic [3:0]            nibble_c;
  logic [SEG_W-1:0]      seg_c;
  logic                  lit_c;

  assign off_c = BUS_ADDR - BASE_ADDR;
  assign wr_c  = BUS_WE && (BUS_ADDR >= BASE_ADDR) && (32'(off_c) < NUM_REGS);

  // Register file write decode
  always_comb begin
    value_d = value_q;
    dp_d    = dp_q;
    en_d    = en_q;
    if (wr_c) begin
      for (int unsigned k = 0; k < H; k++) begin
        if (off_c == 8'(k)) value_d[VAL_W-1-8*k -: 8] = BUS_DATA;
      end
      if (off_c == 8'(H + OFF_DP)) dp_d = BUS_DATA[NUM_DIGITS-1:0];
      if (off_c == 8'(H + OFF_EN)) en_d = BUS_DATA[NUM_DIGITS-1:0];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      value_q <= '0;
      dp_q    <= '0;
      en_q    <= '1;
    end else begin
      value_q <= value_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
    end
  end

`ifdef SEG7_MUX_BRIGHTNESS_EN
  logic [3:0] bright_q, bright_d;
  logic [3:0] pwm_q, pwm_d;

  // PWM phase restarts at every DRIVE entry so each slot sees the same pattern
  always_comb begin
    bright_d = bright_q;
    if (wr_c && off_c == 8'(H + OFF_BRIGHT)) bright_d = BUS_DATA[3:0];
    pwm_d = pwm_q;
    if (state_q == ST_BLANK && state_d == ST_DRIVE) pwm_d = '0;
    else if (state_q == ST_DRIVE)                    pwm_d = pwm_q + 4'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bright_q <= 4'hF;
      pwm_q    <= '0;
    end else begin
      bright_q <= bright_d;
      pwm_q    <= pwm_d;
    end
  end

  assign lit_c = (pwm_q <= bright_q);
`else
  assign lit_c = 1'b1;
`endif

  assign nibble_c = value_q[4*idx_q +: 4];

  seg7_hex_decode u_dec (
    .digit_i (nibble_c),
    .seg_o   (seg_c)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_BLANK;
      presc_q <= '0;
      idx_q   <= '0;
      hex_q   <= 8'hFF;
      sel_q   <= '1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      hex_q   <= hex_d;
      sel_q   <= sel_d;
    end
  end

  // Scan sequencing and next output image
  always_comb begin
    state_d = state_q;
    presc_d = presc_q + PRESC_W'(1);
    idx_d   = idx_q;
    hex_d   = 8'hFF;
    sel_d   = '1;
    if (presc_q == PRESC_W'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      state_d = ST_BLANK;
      idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else if (state_q == ST_BLANK && (32'(presc_q) + 1 >= BLANK_CYCLES)) begin
      state_d = ST_DRIVE;
    end
    if (state_q == ST_DRIVE && lit_c) begin
      hex_d        = {~dp_q[idx_q], seg_c};
      sel_d[idx_q] = ~en_q[idx_q];
    end
  end

  assign HEX_OUT    = hex_q;
  assign SEG_SELECT = sel_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver: a 4-digit instance at 8'hD0 and an 8-digit instance at 8'h40.
module tb_seg7_mux_driver;

  localparam int unsigned RDIV = 40;
  localparam int unsigned BLK  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_addr, a_data, b_addr, b_data;
  logic       a_we, b_we;
  logic [7:0] a_hex, b_hex;
  logic [3:0] a_sel;
  logic [7:0] b_sel;

  int unsigned cyc;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  seg7_mux_driver #(.BASE_ADDR(8'hD0), .NUM_DIGITS(4), .REFRESH_DIV(RDIV), .BLANK_CYCLES(BLK)) u_dut_a (
    .CLK(clk), .RESET(rst), .BUS_ADDR(a_addr), .BUS_DATA(a_data), .BUS_WE(a_we),
    .HEX_OUT(a_hex), .SEG_SELECT(a_sel)
  );

  seg7_mux_driver #(.BASE_ADDR(8'h40), .NUM_DIGITS(8), .REFRESH_DIV(RDIV), .BLANK_CYCLES(BLK)) u_dut_b (
    .CLK(clk), .RESET(rst), .BUS_ADDR(b_addr), .BUS_DATA(b_data), .BUS_WE(b_we),
    .HEX_OUT(b_hex), .SEG_SELECT(b_sel)
  );

  // Rising edges since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic at(input int unsigned k);
    int unsigned guard = 0;
    while (cyc < k && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) check("sync_cycle", cyc, k);
  endtask

  task automatic wr_a(input logic [7:0] addr, input logic [7:0] data);
    a_addr = addr; a_data = data; a_we = 1'b1;
    @(negedge clk);
    a_we = 1'b0;
  endtask

  task automatic wr_b(input logic [7:0] addr, input logic [7:0] data);
    b_addr = addr; b_data = data; b_we = 1'b1;
    @(negedge clk);
    b_we = 1'b0;
  endtask

  task automatic chk_a(input string tag, input int unsigned k, input logic [7:0] hex, input logic [3:0] sel);
    at(k);
    check({tag, "_hex"}, a_hex, hex);
    check({tag, "_sel"}, a_sel, sel);
  endtask

  task automatic chk_b(input string tag, input int unsigned k, input logic [7:0] hex, input logic [7:0] sel);
    at(k);
    check({tag, "_hex"}, b_hex, hex);
    check({tag, "_sel"}, b_sel, sel);
  endtask

  initial begin
    rst = 1'b1;
    a_addr = '0; a_data = '0; a_we = 1'b0;
    b_addr = '0; b_data = '0; b_we = 1'b0;
    @(negedge clk);
    check("rst_a_hex", a_hex, 8'hFF);
    check("rst_a_sel", a_sel, 4'hF);
    check("rst_b_sel", b_sel, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    chk_a("a_cyc0", 0, 8'hFF, 4'hF);

    wr_b(8'h48, 8'hFF);
    wr_b(8'h3F, 8'hFF);
    wr_b(8'h43, 8'h5A);
`ifdef SEG7_MUX_BRIGHTNESS_EN
    wr_a(8'hD4, 8'h03);
`endif

    chk_a("a_blank_last", 16, 8'hFF, 4'hF);
`ifdef SEG7_MUX_BRIGHTNESS_EN
    chk_a("pwm_on0", 18, 8'hC0, 4'hE);
    chk_b("b_d0", 20, 8'h88, 8'hFE);
    chk_a("pwm_off5", 22, 8'hFF, 4'hF);
    chk_a("pwm_on17", 34, 8'hC0, 4'hE);
`else
    chk_a("a_d0_first", 17, 8'hC0, 4'hE);
    chk_b("b_d0", 20, 8'h88, 8'hFE);
    chk_a("a_d0_last", 40, 8'hC0, 4'hE);
`endif
    chk_a("a_d1_blank", 41, 8'hFF, 4'hF);
    chk_a("a_d1", 57, 8'hC0, 4'hD);
    chk_b("b_d1", 60, 8'h92, 8'hFD);
    chk_a("a_d2", 97, 8'hC0, 4'hB);
    chk_b("b_d2", 100, 8'hC0, 8'hFB);
    chk_a("a_d3", 137, 8'hC0, 4'h7);

    at(141);
    wr_a(8'hD0, 8'h12);
    wr_a(8'hD1, 8'hAB);
    chk_a("val_d0", 177, 8'h83, 4'hE);
    chk_a("val_blank", 201, 8'hFF, 4'hF);
    chk_a("val_d1", 217, 8'h88, 4'hD);
    chk_a("val_d2", 257, 8'hA4, 4'hB);
    chk_a("val_d3", 297, 8'hF9, 4'h7);
    chk_b("b_d7", 300, 8'hC0, 8'h7F);

    at(322);
    wr_a(8'hD2, 8'h05);
    chk_a("dp_d0", 340, 8'h03, 4'hE);
    chk_a("dp_d1", 380, 8'h88, 4'hD);
    chk_a("dp_d2", 420, 8'h24, 4'hB);
    chk_a("dp_d3", 460, 8'hF9, 4'h7);

    at(462);
    wr_a(8'hD3, 8'h0D);
`ifndef SEG7_MUX_BRIGHTNESS_EN
    wr_a(8'hD4, 8'h00);
`endif
    wr_a(8'hD5, 8'hFF);
    wr_a(8'hCF, 8'hFF);
    chk_a("en_d0", 500, 8'h03, 4'hE);
    at(540);
    check("en_d1_off_sel", a_sel, 4'hF);
    chk_a("en_d2_blank", 576, 8'hFF, 4'hF);
    chk_a("en_d2_first", 577, 8'h24, 4'hB);
    chk_a("en_d3", 620, 8'hF9, 4'h7);

    at(745);
    rst = 1'b1;
    #1;
    check("async_a_hex", a_hex, 8'hFF);
    check("async_a_sel", a_sel, 4'hF);
    check("async_b_sel", b_sel, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
`ifdef SEG7_MUX_BRIGHTNESS_EN
    wr_a(8'hD4, 8'h03);
`endif
    chk_a("rr_blank", 16, 8'hFF, 4'hF);
    chk_a("rr_d0", 18, 8'hC0, 4'hE);
    chk_b("rr_b_d0", 20, 8'hC0, 8'hFE);
    chk_a("rr_d1", 58, 8'hC0, 4'hD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
